// File: rtl/toy_bus_resp_node.sv
// Toy-bus target responder: runs each request against an SRAM-style port and queues one ack.
// Optional define TOY_BUS_RESP_TGT_CHK_EN rejects requests whose tgt_id differs from NODE_ID.
module toy_bus_resp_node #(
    parameter logic [3:0]  NODE_ID   = 4'd1,
    parameter int unsigned ACK_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_req_vld,
    output logic         in_req_rdy,
    input  logic [31:0]  in_req_addr,
    input  logic [31:0]  in_req_strb,
    input  logic [255:0] in_req_data,
    input  logic         in_req_opcode,
    input  logic [3:0]   in_req_src_id,
    input  logic [3:0]   in_req_tgt_id,
    input  logic [31:0]  in_req_sideband,
    output logic         out_ack_vld,
    input  logic         out_ack_rdy,
    output logic         out_ack_opcode,
    output logic [255:0] out_ack_data,
    output logic [31:0]  out_ack_sideband,
    output logic [3:0]   out_ack_src_id,
    output logic [3:0]   out_ack_tgt_id,
    output logic         mem_vld,
    input  logic         mem_gnt,
    output logic         mem_we,
    output logic [26:0]  mem_addr,
    output logic [31:0]  mem_wstrb,
    output logic [255:0] mem_wdata,
    input  logic [255:0] mem_rdata
);

    localparam int unsigned PtrW = $clog2(ACK_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(ACK_DEPTH);

`ifdef TOY_BUS_RESP_TGT_CHK_EN
    typedef enum logic [1:0] {StIdle, StMem, StRdw, StErr} state_e;
`else
    typedef enum logic [1:0] {StIdle, StMem, StRdw} state_e;
`endif

    state_e state_q, state_d;

    logic         req_op_q;
    logic [26:0]  req_addr_q;
    logic [31:0]  req_strb_q;
    logic [255:0] req_data_q;
    logic [3:0]   req_src_q;
    logic [31:0]  req_sb_q;

    logic         accept;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         pop;
    logic         push_op;
    logic [255:0] push_data;
    logic [31:0]  push_sb;

    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic         ack_op_q   [ACK_DEPTH];
    logic [255:0] ack_data_q [ACK_DEPTH];
    logic [31:0]  ack_sb_q   [ACK_DEPTH];
    logic [3:0]   ack_tgt_q  [ACK_DEPTH];

    // Low address bits select bytes within the word and are carried by strb instead.
    logic unused_in;
`ifdef TOY_BUS_RESP_TGT_CHK_EN
    assign unused_in = ^in_req_addr[4:0];
`else
    assign unused_in = ^{in_req_addr[4:0], in_req_tgt_id};
`endif

    assign fifo_full  = (cnt_q == FullCnt);
    assign fifo_empty = (cnt_q == '0);
    assign accept     = in_req_vld & in_req_rdy;
    assign pop        = out_ack_vld & out_ack_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
`ifdef TOY_BUS_RESP_TGT_CHK_EN
                    state_d = (in_req_tgt_id != NODE_ID) ? StErr : StMem;
`else
                    state_d = StMem;
`endif
                end
            end
            StMem: begin
                if (mem_gnt) begin
                    state_d = req_op_q ? StIdle : StRdw;
                end
            end
            StRdw: state_d = StIdle;
`ifdef TOY_BUS_RESP_TGT_CHK_EN
            StErr: state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_req_rdy = ~rst & (state_q == StIdle) & ~fifo_full;
        mem_vld    = (state_q == StMem);
        push       = 1'b0;
        push_op    = req_op_q;
        push_data  = '0;
        push_sb    = req_sb_q;
        case (state_q)
            StMem: push = mem_gnt & req_op_q;
            StRdw: begin
                push      = 1'b1;
                push_data = mem_rdata;
            end
`ifdef TOY_BUS_RESP_TGT_CHK_EN
            StErr: begin
                push    = 1'b1;
                push_sb = req_sb_q | 32'h8000_0000;
            end
`endif
            default: ;
        endcase
    end

    // Memory controls come straight from the capture registers so they stay stable until grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_op_q   <= 1'b0;
            req_addr_q <= '0;
            req_strb_q <= '0;
            req_data_q <= '0;
            req_src_q  <= '0;
            req_sb_q   <= '0;
        end else if (accept) begin
            req_op_q   <= in_req_opcode;
            req_addr_q <= in_req_addr[31:5];
            req_strb_q <= in_req_strb;
            req_data_q <= in_req_data;
            req_src_q  <= in_req_src_id;
            req_sb_q   <= in_req_sideband;
        end
    end

    assign mem_we    = req_op_q;
    assign mem_addr  = req_addr_q;
    assign mem_wstrb = req_strb_q;
    assign mem_wdata = req_data_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < ACK_DEPTH; i++) begin
                ack_op_q[i]   <= 1'b0;
                ack_data_q[i] <= '0;
                ack_sb_q[i]   <= '0;
                ack_tgt_q[i]  <= '0;
            end
        end else begin
            if (push) begin
                ack_op_q[wr_ptr_q]   <= push_op;
                ack_data_q[wr_ptr_q] <= push_data;
                ack_sb_q[wr_ptr_q]   <= push_sb;
                ack_tgt_q[wr_ptr_q]  <= req_src_q;
                wr_ptr_q             <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    assign out_ack_vld      = ~fifo_empty;
    assign out_ack_opcode   = ack_op_q[rd_ptr_q];
    assign out_ack_data     = ack_data_q[rd_ptr_q];
    assign out_ack_sideband = ack_sb_q[rd_ptr_q];
    assign out_ack_tgt_id   = ack_tgt_q[rd_ptr_q];
    assign out_ack_src_id   = fifo_empty ? 4'd0 : NODE_ID;

endmodule

// File: doc/toy_bus_resp_node.md
Name: toy_bus_resp_node

Overview:
- Target-side responder endpoint for the toy bus: the far end of a LSU decode/arbitrate node.
- Accepts ToyBusReq beats (read/write) and performs the access on a simple SRAM-style memory port.
- Returns one ToyBusAck per request, with src/tgt ids swapped and sideband echoed.
- Sits behind a decoder output port; feeds the ack path back into that node's arbiter.

Parameters:
- NODE_ID, 4'd1, this target's bus id; placed in ack src_id.
- ACK_DEPTH, 2, ack FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_req_vld  in  1  request valid
- in_req_rdy  out  1  request ready
- in_req_addr  in  32  byte address
- in_req_strb  in  32  byte enables for data
- in_req_data  in  256  write data
- in_req_opcode  in  1  0=read, 1=write
- in_req_src_id  in  4  initiator id
- in_req_tgt_id  in  4  target id
- in_req_sideband  in  32  opaque tag
- out_ack_vld  out  1  ack valid
- out_ack_rdy  in  1  ack ready
- out_ack_opcode  out  1  echoed opcode
- out_ack_data  out  256  read data; 0 for writes
- out_ack_sideband  out  32  echoed sideband
- out_ack_src_id  out  4  NODE_ID
- out_ack_tgt_id  out  4  request src_id
- mem_vld  out  1  memory access valid
- mem_gnt  in  1  memory grant; access handshakes on mem_vld&mem_gnt
- mem_we  out  1  write enable
- mem_addr  out  27  word address = req_addr[31:5]
- mem_wstrb  out  32  byte enables
- mem_wdata  out  256  write data
- mem_rdata  in  256  read data, valid exactly 1 cycle after read handshake

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, FIFO empty, all outputs 0 (in_req_rdy=0, out_ack_vld=0, mem_vld=0).
- Request handshake: in_req_vld & in_req_rdy. in_req_rdy = (state==IDLE) & ~fifo_full.
- On accept: capture opcode, addr, strb, data, src_id, sideband; go to MEM.
- FSM states IDLE, MEM, RDW:
  - IDLE→MEM on accept.
  - MEM: mem_vld=1, with stable address/controls. On mem_gnt:
    - write: push ack entry {opcode=1, data=0, sideband, tgt_id=src_id}; go to IDLE.
    - read: go to RDW.
  - RDW: push ack entry {opcode=0, data=mem_rdata, ...}; go to IDLE.
- mem_vld is held until granted; mem_vld must not drop while waiting (protocol rule).
- Minimum latency, with gnt=1 and FIFO empty:
  - write: ack valid 2 cycles after accept.
  - read: ack valid 3 cycles after accept.
- Throughput: one request per 2 cycles (write) or 3 cycles (read).
- Ack FIFO:
  - out_ack_* driven from the head entry; out_ack_vld = ~empty.
  - Pop on out_ack_vld & out_ack_rdy.
  - Simultaneous push and pop when full is impossible, since a push is only reachable after an accept, which required ~full.
  - Push and pop in the same cycle keep the count unchanged.
  - Pointers are log2(ACK_DEPTH) bits with wraparound; count is log2(ACK_DEPTH)+1 bits.
- Ack payload is held stable while out_ack_vld=1 and out_ack_rdy=0.
- Backpressure: with the FIFO full, in_req_rdy=0 until a pop; rdy rises the cycle after the pop.
- Reset asserted mid-access clears the FSM and FIFO immediately and drops mem_vld. An in-flight request is lost; the initiator must reset too.
- Byte strobes are passed through; all-zero strb on a write still performs the mem handshake and acks.

Optional Feature:
- Macro TOY_BUS_RESP_TGT_CHK_EN, when defined:
  - An accepted request with tgt_id != NODE_ID skips MEM/RDW. FSM goes IDLE→ERR (1 cycle).
  - ERR pushes ack {opcode echoed, data=0, sideband = req_sideband | 32'h8000_0000}; no mem_vld is issued.
- When not defined: tgt_id is ignored and every request accesses memory; the ERR state does not exist.

Test Plan:
- Write addr=32'h40, strb=all-ones, data=pattern A, src_id=3, sideband=32'h11, gnt=1 → mem_we=1, mem_addr=27'h2, ack 2 cycles after accept with opcode=1, data=0, src_id=NODE_ID, tgt_id=3, sideband=32'h11.
- Read addr=32'h40; model returns pattern A 1 cycle after grant → ack data=A, opcode=0, 3 cycles after accept.
- Hold mem_gnt=0 for 5 cycles during MEM → mem_vld and mem_addr stable all 5 cycles, in_req_rdy=0, ack only after gnt.
- out_ack_rdy=0, issue 3 writes with ACK_DEPTH=2 → two acks queued, third request stalls (in_req_rdy=0). Release rdy → acks in order, third accepted.
- Assert rst during RDW → next cycle out_ack_vld=0, mem_vld=0, in_req_rdy=0; after release, a new read completes normally.
- With TOY_BUS_RESP_TGT_CHK_EN, NODE_ID=1, send tgt_id=2, sideband=32'h5 → no mem_vld, ack sideband=32'h8000_0005, data=0.
